sparse_core_unit: RTL and testbench



---
 rtl/sparse_core_unit.sv | 77 +++++++
 tb/tb_sparse_core_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sparse_core_unit.sv
// 2:4 structured-sparse matrix-vector multiply-accumulate engine.
// Each row picks two activations by index, multiplies by its two weights and accumulates.
module sparse_core_unit #(
   parameter int NUM_ROWS = 4,
   parameter int VEC_LEN  = 4,
   parameter int DATA_W   = 8,
   parameter int IDX_W    = 2,
   parameter int ACC_W    = 20
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              en,
   input  logic [NUM_ROWS-1:0][2*DATA_W+2*IDX_W-1:0]         w_rows,
   input  logic [VEC_LEN-1:0][DATA_W-1:0]                    act_vec,
   output logic [NUM_ROWS-1:0][ACC_W-1:0]                    psum_out
);

   localparam int PKT_W  = 2*DATA_W + 2*IDX_W;
   localparam int PROD_W = 2*DATA_W;
   localparam int SUM_W  = 2*DATA_W + 1;

   generate
      for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
         logic [DATA_W-1:0] val_0;
         logic [DATA_W-1:0] val_1;
         logic [IDX_W-1:0]  idx_0;
         logic [IDX_W-1:0]  idx_1;
         logic [DATA_W-1:0] act_0;
         logic [DATA_W-1:0] act_1;
         logic [PROD_W-1:0] val_0_ext;
         logic [PROD_W-1:0] val_1_ext;
         logic [PROD_W-1:0] act_0_ext;
         logic [PROD_W-1:0] act_1_ext;
         logic [PROD_W-1:0] prod_0;
         logic [PROD_W-1:0] prod_1;
         logic [SUM_W-1:0]  term_sum;
         logic [ACC_W-1:0]  term_ext;
         logic [ACC_W-1:0]  acc_reg;
         logic [ACC_W-1:0]  acc_next;

         // Packet layout, MSB first: val_0, val_1, idx_0, idx_1.
         assign val_0 = w_rows[gi][PKT_W-1 -: DATA_W];
         assign val_1 = w_rows[gi][PKT_W-DATA_W-1 -: DATA_W];
         assign idx_0 = w_rows[gi][2*IDX_W-1 -: IDX_W];
         assign idx_1 = w_rows[gi][IDX_W-1:0];

         assign act_0 = act_vec[idx_0];
         assign act_1 = act_vec[idx_1];

         // Operands widened to the full product width so the low half is the exact signed product.
         assign val_0_ext = {{DATA_W{val_0[DATA_W-1]}}, val_0};
         assign val_1_ext = {{DATA_W{val_1[DATA_W-1]}}, val_1};
         assign act_0_ext = {{DATA_W{act_0[DATA_W-1]}}, act_0};
         assign act_1_ext = {{DATA_W{act_1[DATA_W-1]}}, act_1};

         assign prod_0 = val_0_ext * act_0_ext;
         assign prod_1 = val_1_ext * act_1_ext;

         assign term_sum = {prod_0[PROD_W-1], prod_0} + {prod_1[PROD_W-1], prod_1};
         assign term_ext = {{(ACC_W-SUM_W){term_sum[SUM_W-1]}}, term_sum};

         // Modulo-2^ACC_W wrap is intended; no saturation.
         assign acc_next = acc_reg + term_ext;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               acc_reg <= '0;
            end else if (en) begin
               acc_reg <= acc_next;
            end
         end

         assign psum_out[gi] = acc_reg;
      end
   endgenerate

endmodule

// File: tb/tb_sparse_core_unit.sv
// Directed bench for sparse_core_unit: vector table plus hand sequences for reset and wrap.
module tb_sparse_core_unit;

   localparam int NUM_ROWS = 4;
   localparam int VEC_LEN  = 4;
   localparam int DATA_W   = 8;
   localparam int IDX_W    = 2;
   localparam int ACC_W    = 20;
   localparam int PKT_W    = 2*DATA_W + 2*IDX_W;

   typedef logic [NUM_ROWS-1:0][PKT_W-1:0]  w_t;
   typedef logic [VEC_LEN-1:0][DATA_W-1:0]  act_t;
   typedef logic [NUM_ROWS-1:0][ACC_W-1:0]  psum_t;

   typedef struct {
      string name;
      logic  en;
      int    reps;
      act_t  act;
      w_t    w;
      psum_t exp;
   } vec_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  en  = 1'b0;
   w_t    w_rows = '0;
   act_t  act_vec = '0;
   psum_t psum_out;

   int checks_total  = 0;
   int checks_passed = 0;

   sparse_core_unit #(
      .NUM_ROWS (NUM_ROWS),
      .VEC_LEN  (VEC_LEN),
      .DATA_W   (DATA_W),
      .IDX_W    (IDX_W),
      .ACC_W    (ACC_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .w_rows   (w_rows),
      .act_vec  (act_vec),
      .psum_out (psum_out)
   );

   always #5 clk = ~clk;

   function automatic logic [PKT_W-1:0] pkt(input int v0, input int v1, input int i0, input int i1);
      logic [DATA_W-1:0] b0;
      logic [DATA_W-1:0] b1;
      logic [IDX_W-1:0]  x0;
      logic [IDX_W-1:0]  x1;
      b0 = DATA_W'(v0);
      b1 = DATA_W'(v1);
      x0 = IDX_W'(i0);
      x1 = IDX_W'(i1);
      return {b0, b1, x0, x1};
   endfunction

   function automatic w_t mk_w(input logic [PKT_W-1:0] p0, input logic [PKT_W-1:0] p1,
                               input logic [PKT_W-1:0] p2, input logic [PKT_W-1:0] p3);
      w_t w;
      w[0] = p0; w[1] = p1; w[2] = p2; w[3] = p3;
      return w;
   endfunction

   function automatic act_t mk_act(input int a0, input int a1, input int a2, input int a3);
      act_t a;
      a[0] = DATA_W'(a0); a[1] = DATA_W'(a1); a[2] = DATA_W'(a2); a[3] = DATA_W'(a3);
      return a;
   endfunction

   function automatic psum_t mk_psum(input int e0, input int e1, input int e2, input int e3);
      psum_t p;
      p[0] = ACC_W'(e0); p[1] = ACC_W'(e1); p[2] = ACC_W'(e2); p[3] = ACC_W'(e3);
      return p;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rows(input string name, input psum_t exp);
      for (int r = 0; r < NUM_ROWS; r++) begin
         checks_total++;
         if (psum_out[r] === exp[r]) begin
            checks_passed++;
         end else begin
            $display("FAIL %s row%0d: got %0d (0x%05h), expected %0d (0x%05h)",
                     name, r, $signed(psum_out[r]), psum_out[r], $signed(exp[r]), exp[r]);
         end
      end
   endtask

   vec_t  tbl[7];
   act_t  base_act;
   w_t    base_w;
   psum_t single_exp;
   psum_t zero_exp;
   psum_t ext_exp;

   initial begin
      base_act   = mk_act(1, 2, 3, 4);
      base_w     = mk_w(pkt(5, 7, 0, 2), pkt(-3, 2, 1, 3), pkt(1, 1, 3, 3), pkt(0, 0, 0, 1));
      single_exp = mk_psum(26, 2, 8, 0);
      zero_exp   = mk_psum(0, 0, 0, 0);

      tbl[0] = '{"single",   1'b1, 1,  base_act, base_w, single_exp};
      tbl[1] = '{"hold",     1'b0, 10, base_act, base_w, single_exp};
      tbl[2] = '{"second",   1'b1, 1,  base_act, base_w, mk_psum(52, 4, 16, 0)};
      tbl[3] = '{"idle_chg", 1'b0, 10, mk_act(-1, 10, 0, 2),
                 mk_w(pkt(3, 4, 1, 3), pkt(-2, -5, 0, 1), pkt(127, -1, 3, 0), pkt(1, 1, 2, 2)),
                 mk_psum(52, 4, 16, 0)};
      tbl[4] = '{"acc_a",    1'b1, 1,  mk_act(-1, 10, 0, 2),
                 mk_w(pkt(3, 4, 1, 3), pkt(-2, -5, 0, 1), pkt(127, -1, 3, 0), pkt(1, 1, 2, 2)),
                 mk_psum(90, -44, 271, 0)};
      tbl[5] = '{"acc_b",    1'b1, 1,  mk_act(5, -6, 7, -8),
                 mk_w(pkt(1, 2, 0, 1), pkt(3, 0, 2, 0), pkt(-1, -1, 3, 3), pkt(10, -10, 0, 2)),
                 mk_psum(83, -23, 287, -20)};
      tbl[6] = '{"acc_c",    1'b1, 1,  mk_act(100, 100, 100, 100),
                 mk_w(pkt(-100, 1, 0, 0), pkt(2, 2, 1, 2), pkt(0, 0, 0, 0), pkt(50, 50, 3, 1)),
                 mk_psum(-9817, 377, 287, 9980)};

      // Reset held: en pulses with live inputs must not accumulate.
      step();
      check_rows("reset", zero_exp);
      act_vec = base_act;
      w_rows  = base_w;
      en      = 1'b1;
      step();
      step();
      check_rows("en_in_reset", zero_exp);
      en  = 1'b0;
      rst = 1'b0;
      repeat (3) step();
      check_rows("post_reset_idle", zero_exp);

      for (int i = 0; i < 7; i++) begin
         act_vec = tbl[i].act;
         w_rows  = tbl[i].w;
         en      = tbl[i].en;
         for (int k = 0; k < tbl[i].reps; k++) begin
            step();
            check_rows(tbl[i].name, tbl[i].exp);
         end
         en = 1'b0;
      end

      // Asynchronous reset between edges, then a fresh single pulse.
      act_vec = base_act;
      w_rows  = base_w;
      en      = 1'b1;
      step();
      en = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_rows("async_rst", zero_exp);
      #1 rst = 1'b0;
      step();
      check_rows("after_async_rst", zero_exp);
      en = 1'b1;
      step();
      en = 1'b0;
      check_rows("restart_single", single_exp);

      // Signed extremes: each row-0 term is (-128*-128)*2 = 32768.
      rst = 1'b1;
      #2 rst = 1'b0;
      act_vec = mk_act(-128, 0, 0, 0);
      w_rows  = mk_w(pkt(-128, -128, 0, 0), pkt(0, 0, 0, 0), pkt(0, 0, 0, 0), pkt(0, 0, 0, 0));
      en = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         step();
         ext_exp = mk_psum(32768 * c, 0, 0, 0);
         if (c == 1)  check_rows("ext_x1", ext_exp);
         if (c == 15) check_rows("ext_x15", ext_exp);
         if (c == 16) check_rows("ext_x16_signbit", ext_exp);
         if (c == 32) check_rows("ext_x32_wrap0", zero_exp);
      end
      en = 1'b0;
      repeat (2) step();
      check_rows("ext_hold", zero_exp);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
